// File: rtl/serial_frame_pkg.sv
// Shared state encodings and constants for serial_frame_tx.
// Defining SERIAL_FRAME_PREAMBLE_EN adds the 1110 sync preamble ahead of every frame.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        SEND  = 2'b10,
        STUFF = 2'b11
    } tx_state_e;

    localparam logic [3:0] PREAMBLE = 4'b1110;
    localparam int         RUN_MAX  = 2;

`ifdef SERIAL_FRAME_PREAMBLE_EN
    localparam int PRE_LEN = 4;
`else
    localparam int PRE_LEN = 0;
`endif

    // Worst case is one stuffed zero after every pair of payload ones.
    function automatic int max_frame_len(input int width);
        return PRE_LEN + width + width / 2;
    endfunction

endpackage

// File: rtl/serial_frame_tx_shift_reg.sv
// Loadable MSB-first payload shift register with an emitted-bit counter.
// load and shift in the same cycle emit din's MSB while capturing the rest.
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             next_bit,
    output logic             last_bit
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q, sh_d, src;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;

    always_comb begin
        src      = load ? din : sh_q;
        cnt_base = load ? '0 : cnt_q;
        sh_d     = sh_q;
        cnt_d    = cnt_base;
        if (shift) begin
            sh_d  = {src[WIDTH-2:0], 1'b0};
            cnt_d = cnt_base + CW'(1);
        end else if (load) begin
            sh_d = src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign next_bit = src[WIDTH-1];
    // High once every payload bit has been put on the line.
    assign last_bit = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/serial_frame_tx.sv
// Zero-stuffing serial frame transmitter; the payload never carries three consecutive 1s.
// Optional 1110 preamble under SERIAL_FRAME_PREAMBLE_EN.
module serial_frame_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             data,
    output logic             done
);
    import serial_frame_pkg::*;

    // state_q names the kind of bit currently on data; data_d is the bit for state_d.
    tx_state_e  state_q, state_d;
    logic [1:0] run_q, run_d;
    logic       data_q, data_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic       sr_load, sr_shift, pbit, last_bit;
    logic       accept;
`ifdef SERIAL_FRAME_PREAMBLE_EN
    logic [1:0] pre_cnt_q, pre_cnt_d;
`endif

    assign accept = load && ready_q;

    tx_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sr_load),
        .shift    (sr_shift),
        .din      (din),
        .next_bit (pbit),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        data_d   = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
`ifdef SERIAL_FRAME_PREAMBLE_EN
        pre_cnt_d = pre_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
`ifdef SERIAL_FRAME_PREAMBLE_EN
                    state_d   = SYNC;
                    pre_cnt_d = 2'd0;
                    data_d    = PREAMBLE[3];
                    run_d     = 2'd0;
`else
                    sr_shift = 1'b1;
                    state_d  = SEND;
                    data_d   = pbit;
                    run_d    = {1'b0, pbit};
`endif
                end
            end
`ifdef SERIAL_FRAME_PREAMBLE_EN
            SYNC: begin
                if (pre_cnt_q != 2'd3) begin
                    pre_cnt_d = pre_cnt_q + 2'd1;
                    data_d    = PREAMBLE[2'd2 - pre_cnt_q];
                end else begin
                    pre_cnt_d = 2'd0;
                    sr_shift  = 1'b1;
                    state_d   = SEND;
                    data_d    = pbit;
                    run_d     = {1'b0, pbit};
                end
            end
`endif
            SEND: begin
                // A pending stuff outranks end-of-payload so the frame never ends on 11.
                if (run_q == 2'(RUN_MAX)) begin
                    state_d = STUFF;
                    run_d   = 2'd0;
                end else if (last_bit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                    data_d   = pbit;
                    run_d    = pbit ? run_q + 2'd1 : 2'd0;
                end
            end
            STUFF: begin
                if (last_bit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                    state_d  = SEND;
                    data_d   = pbit;
                    run_d    = {1'b0, pbit};
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 2'd0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

`ifdef SERIAL_FRAME_PREAMBLE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt_q <= 2'd0;
        else        pre_cnt_q <= pre_cnt_d;
    end
`endif

    assign data  = data_q;
    assign done  = done_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: per-cycle expected line values queued on accept.
module tb_serial_frame_tx;
    localparam int W = 8;
`ifdef SERIAL_FRAME_PREAMBLE_EN
    localparam int PRE_FIRES = 1;
`else
    localparam int PRE_FIRES = 0;
`endif

    typedef struct packed {
        logic d;
        logic dn;
    } exp_t;

    logic         clk, rst_n, load;
    logic [W-1:0] din;
    logic         ready, busy, data, done;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   fires = 0;
    logic [2:0] win = 3'b000;

    serial_frame_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (din),
        .ready (ready),
        .busy  (busy),
        .data  (data),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        int run = 0;
`ifdef SERIAL_FRAME_PREAMBLE_EN
        q.push_back('{1'b1, 1'b0});
        q.push_back('{1'b1, 1'b0});
        q.push_back('{1'b1, 1'b0});
        q.push_back('{1'b0, 1'b0});
`endif
        for (int i = W - 1; i >= 0; i--) begin
            q.push_back('{w[i], 1'b0});
            run = w[i] ? run + 1 : 0;
            if (run == 2) begin
                q.push_back('{1'b0, 1'b0});
                run = 0;
            end
        end
        q.push_back('{1'b0, 1'b1});
    endtask

    // Monitor: compare the line once per cycle on the falling edge, then model acceptance.
    always @(negedge clk) begin
        exp_t e;
        logic mready;
        if (!rst_n) begin
            q.delete();
            win   = 3'b000;
            fires = 0;
        end else begin
            e      = '{1'b0, 1'b0};
            mready = 1'b1;
            if (q.size() > 0) begin
                e      = q.pop_front();
                mready = e.dn;
            end
            chk("data", data, e.d);
            chk("done", done, e.dn);
            chk("ready", ready, mready);
            chk("busy", busy, !mready);
            win = {win[1:0], data};
            if (win == 3'b111) fires++;
            if (e.dn) begin
                chk("det_fires", fires, PRE_FIRES);
                fires = 0;
            end
            if (load && mready) begin
                push_frame(din);
                accepts++;
            end
        end
    end

    task automatic wait_acc(input int a0);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (accepts != a0) begin
                ok = 1;
                break;
            end
        end
        #1;
        if (!ok) chk("tmo_accept", 0, 1);
    endtask

    task automatic send(input logic [W-1:0] w);
        int a0 = accepts;
        din  = w;
        load = 1'b1;
        wait_acc(a0);
        load = 1'b0;
    endtask

    // din is scrambled while waiting so a bus change mid-frame would show up on data.
    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
            din = W'($urandom);
        end
        if (!ok) chk("tmo_idle", 0, 1);
    endtask

    task automatic reset_now();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_data", data, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int a0;
        clk   = 1'b0;
        rst_n = 1'b1;
        load  = 1'b0;
        din   = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("init_data", data, 0);
        chk("init_ready", ready, 1);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        // load during reset must not start a frame
        load = 1'b1;
        din  = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send(8'hA5); wait_idle();
        send(8'hFF); wait_idle();
        send(8'h80); wait_idle();
        send(8'h00); wait_idle();

        // load held high across two frames: second accepted in the done cycle
        a0   = accepts;
        din  = 8'h01;
        load = 1'b1;
        wait_acc(a0);
        din  = 8'h03;
        a0   = accepts;
        wait_acc(a0);
        load = 1'b0;
        wait_idle();

        // reset mid-frame, then after 3 bits of FF, then a full FF reload
        send(8'hA5);
        repeat (4) @(negedge clk);
        reset_now();
        repeat (2) @(posedge clk);
        #1;
        send(8'hFF);
        repeat (2) @(negedge clk);
        reset_now();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        send(8'hFF); wait_idle();

        for (int k = 0; k < 5; k++) begin
            send(W'($urandom));
            wait_idle();
        end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
